// File: rtl/uart_ddr_wr_sched.sv
// Packs RX FIFO bytes into 128-bit DDR write words and issues one request per word.
// Optional UART_DDR_FLUSH_EN macro: flush a partial word after IDLE_TIMEOUT empty cycles.
module uart_ddr_wr_sched #(
  parameter int                ADDR_W       = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                ADDR_STEP    = 16,
  parameter int                IDLE_TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_fifo_empty,
  input  logic [7:0]        i_fifo_data,
  output logic              o_fifo_rden,
  output logic              o_ddr_req,
  input  logic              i_ddr_ack,
  output logic [ADDR_W-1:0] o_ddr_addr,
  output logic [127:0]      o_ddr_wdata,
  output logic [15:0]       o_ddr_mask,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, REQ} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t              state_q, state_d;
  logic [3:0]          byte_cnt_q;
  logic [127:0]        wdata_q;
  logic [15:0]         mask_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                flush;

`ifdef UART_DDR_FLUSH_EN
  localparam int            CW  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(IDLE_TIMEOUT);
  logic [CW-1:0] idle_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      idle_cnt_q <= '0;
    end else if (state_q == IDLE && byte_cnt_q != 4'd0 && i_fifo_empty) begin
      if (idle_cnt_q != TMO) idle_cnt_q <= idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_q <= '0;
    end
  end

  assign flush = (state_q == IDLE) && (byte_cnt_q != 4'd0) && (idle_cnt_q == TMO);
`else
  logic unused_cfg;
  assign unused_cfg = ^IDLE_TIMEOUT;
  assign flush      = 1'b0;
`endif

  // Strobe only when data is really there, so an empty-toggling FIFO just stalls FETCH.
  assign o_fifo_rden = i_rstn && (state_q == FETCH) && !i_fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = REQ;
               else if (!i_fifo_empty) state_d = FETCH;
      FETCH:   if (!i_fifo_empty) state_d = LATCH;
      LATCH:   if (byte_cnt_q == 4'd15) state_d = REQ;
               else if (!i_fifo_empty) state_d = FETCH;
               else state_d = IDLE;
      REQ:     if (i_ddr_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      addr_q     <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      if (state_q == LATCH) begin
        wdata_q[{byte_cnt_q, 3'b000} +: 8] <= i_fifo_data;
        mask_q[byte_cnt_q]                 <= 1'b1;
        byte_cnt_q                         <= byte_cnt_q + 4'd1;
      end
      if (state_q == REQ && i_ddr_ack) begin
        addr_q     <= addr_q + STEP;
        byte_cnt_q <= '0;
        wdata_q    <= '0;
        mask_q     <= '0;
      end
    end
  end

  assign o_ddr_req   = (state_q == REQ);
  assign o_ddr_addr  = addr_q;
  assign o_ddr_wdata = wdata_q;
  assign o_ddr_mask  = mask_q;
  assign o_busy      = (state_q != IDLE) || (byte_cnt_q != 4'd0);

endmodule

// File: tb/tb_uart_ddr_wr_sched.sv
// Random-stimulus bench: byte-stream scoreboard forms expected DDR words and addresses.
module tb_uart_ddr_wr_sched;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rstn, fifo_empty, ack;
  logic [7:0]   fifo_data;
  logic         rden, req, busy;
  logic [27:0]  addr;
  logic [127:0] wdata;
  logic [15:0]  mask;
  logic         w_rden, w_req, w_busy;
  logic [7:0]   w_addr;
  logic [127:0] w_wdata;
  logic [15:0]  w_mask;

  uart_ddr_wr_sched #(.ADDR_W(28), .BASE_ADDR(28'h0), .ADDR_STEP(16), .IDLE_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rden(rden), .o_ddr_req(req), .i_ddr_ack(ack), .o_ddr_addr(addr),
    .o_ddr_wdata(wdata), .o_ddr_mask(mask), .o_busy(busy));

  uart_ddr_wr_sched #(.ADDR_W(8), .BASE_ADDR(8'hF0), .ADDR_STEP(16), .IDLE_TIMEOUT(TMO)) u_wrap (
    .i_clk(clk), .i_rstn(rstn), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rden(w_rden), .o_ddr_req(w_req), .i_ddr_ack(ack), .o_ddr_addr(w_addr),
    .o_ddr_wdata(w_wdata), .o_ddr_mask(w_mask), .o_busy(w_busy));

  always #5 clk = ~clk;

  logic [7:0]   fifo_q[$];
  logic [7:0]   held[$];
  logic [7:0]   pend_byte;
  logic [27:0]  exp_addr;
  logic [7:0]   exp_waddr;
  logic [27:0]  s_addr, last_addr;
  logic [127:0] s_wdata, last_wdata;
  logic [15:0]  s_mask, last_mask;
  int  checks = 0, passes = 0, cyc = 0;
  int  req_cnt = 0, ack_delay = 3, n_words = 0;
  int  first_rden_cyc = -1, req_rise_cyc = -1;
  bit  toggle_mode = 0, phase = 0, spurious = 0, popped = 0, req_prev = 0, acc_prev = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic monitor();
    logic [127:0] ew;
    logic [15:0]  em;
    int n;
    if (rden) begin
      chk("rden_not_empty", fifo_empty, 0);
      chk("rden_not_in_req", req, 0);
      if (fifo_q.size() > 0) begin
        pend_byte = fifo_q.pop_front();
        held.push_back(pend_byte);
        popped = 1;
      end
      if (first_rden_cyc < 0) first_rden_cyc = cyc;
    end
    if (acc_prev) chk("req_drop", req, 0);
    if (req && !req_prev) begin
      req_rise_cyc = cyc; s_addr = addr; s_wdata = wdata; s_mask = mask;
    end else if (req) begin
      chk("stable_addr", addr, s_addr);
      chk("stable_wdata", wdata, s_wdata);
      chk("stable_mask", mask, s_mask);
    end
    acc_prev = 0;
    if (req && ack) begin
      n = (held.size() > 16) ? 16 : held.size();
      ew = '0; em = '0;
      for (int i = 0; i < n; i++) begin
        ew[8*i +: 8] = held[i];
        em[i] = 1'b1;
      end
`ifndef UART_DDR_FLUSH_EN
      chk("word_full", n, 16);
`endif
      chk("word_addr", addr, exp_addr);
      chk("word_wdata", wdata, ew);
      chk("word_mask", mask, em);
      chk("wrap_addr", w_addr, exp_waddr);
      for (int i = 0; i < n; i++) void'(held.pop_front());
      exp_addr  = exp_addr + 28'd16;
      exp_waddr = exp_waddr + 8'd16;
      last_addr = addr; last_wdata = wdata; last_mask = mask;
      n_words++;
      acc_prev = 1;
    end
    if (held.size() > 0 || req) chk("busy", busy, 1);
    req_prev = req;
  endtask

  task automatic drive();
    if (popped) begin
      fifo_data = pend_byte;
      popped = 0;
    end
    phase = ~phase;
    fifo_empty = (fifo_q.size() == 0) || (toggle_mode && phase);
    if (req) begin
      req_cnt++;
      ack = (req_cnt > ack_delay);
    end else begin
      req_cnt = 0;
      ack = spurious && ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rstn) monitor();
    else begin req_prev = 0; acc_prev = 0; end
    @(posedge clk);
    #1;
    drive();
    cyc++;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
  endtask

  task automatic run_idle();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cycle();
`ifdef UART_DDR_FLUSH_EN
      done = (fifo_q.size() == 0) && !req && (held.size() == 0);
`else
      done = (fifo_q.size() == 0) && !req && (held.size() < 16);
`endif
    end
    chk("drain_done", done, 1);
    repeat (3) cycle();
  endtask

  initial begin
    int words0;
    bit got;
    rstn = 0; fifo_empty = 1; ack = 0; fifo_data = 8'h00;
    exp_addr = 28'h0; exp_waddr = 8'hF0;
    repeat (3) cycle();
    chk("rst_rden", rden, 0);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_mask", mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap_addr", w_addr, 8'hF0);
    rstn = 1;
    cycle();

    // single word of 0x00..0x0F, ack three cycles into the request
    ack_delay = 3; first_rden_cyc = -1;
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
    run_idle();
    chk("t1_words", n_words, 1);
    chk("t1_wdata", last_wdata, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_addr", last_addr, 0);
    chk("t1_mask", last_mask, 16'hFFFF);
    chk("t1_next_addr", addr, 28'd16);
    chk("t1_req_latency", req_rise_cyc - first_rden_cyc, 32);

    // long ack stall across two words
    ack_delay = 20;
    push_rand(32);
    run_idle();
    chk("t2_words", n_words, 3);
    chk("t2_addr", addr, 28'd48);
    chk("t2_wrap_addr", w_addr, 8'h20);

    // five bytes then silence
    ack_delay = 2; first_rden_cyc = -1; words0 = n_words;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'hA0 + i));
    repeat (40) cycle();
`ifdef UART_DDR_FLUSH_EN
    chk("flush_words", n_words, words0 + 1);
    chk("flush_mask", last_mask, 16'h001F);
    chk("flush_wdata", last_wdata, 128'h000000000000000000000000A4A3A2A1A0);
    chk("flush_latency", req_rise_cyc - first_rden_cyc, 2 * 5 + TMO + 1);
`else
    chk("noflush_words", n_words, words0);
    chk("noflush_busy", busy, 1);
    chk("noflush_mask", mask, 16'h001F);
    push_rand(11);
    run_idle();
    chk("fill_words", n_words, words0 + 1);
`endif
    chk("t3_addr", addr, 28'd64);

    // reset while a request is pending
    ack_delay = 1000;
    push_rand(16);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      cycle();
      got = req;
    end
    chk("t4_req_seen", got, 1);
    rstn = 0;
    cycle();
    chk("t4_req_dropped", req, 0);
    chk("t4_addr_base", addr, 0);
    chk("t4_mask_clr", mask, 0);
    chk("t4_wdata_clr", wdata, 0);
    chk("t4_busy_clr", busy, 0);
    held.delete(); exp_addr = 28'h0; exp_waddr = 8'hF0;
    rstn = 1; ack_delay = 2; words0 = n_words;
    push_rand(16);
    run_idle();
    chk("t4_words", n_words, words0 + 1);
    chk("t4_new_addr", last_addr, 0);

    // FIFO empty flag toggling every cycle
    toggle_mode = 1; ack_delay = 1; words0 = n_words;
    push_rand(48);
    run_idle();
    toggle_mode = 0;
    chk("t5_words", n_words, words0 + 3);

    // randomized rounds with spurious acks outside requests
    spurious = 1;
    for (int r = 0; r < 6; r++) begin
      int left;
      ack_delay   = $urandom_range(0, 6);
      toggle_mode = $urandom_range(0, 1) == 1;
      left = 16 * $urandom_range(1, 3);
      while (left > 0) begin
        int k;
        k = $urandom_range(1, left);
        push_rand(k);
        left -= k;
        repeat ($urandom_range(0, 5)) cycle();
      end
      run_idle();
    end
    spurious = 0; toggle_mode = 0;
    repeat (4) cycle();
    chk("final_fifo", fifo_q.size(), 0);
    chk("final_held", held.size(), 0);
    chk("final_addr", addr, exp_addr);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_ddr_wr_sched.md
UART_DDR_WR_SCHED -- requirements
Module: uart_ddr_wr_sched

Interface
REQ-001 Parameter ADDR_W, default 28: DDR byte-address width.
REQ-002 Parameter BASE_ADDR, default 0: first write address after reset.
REQ-003 Parameter ADDR_STEP, default 16: address increment per accepted burst word.
REQ-004 Parameter IDLE_TIMEOUT, default 1024: FIFO-empty cycles before a partial-word flush.
REQ-005 Port i_clk  input  1: clock; all logic SHALL be rising-edge.
REQ-006 Port i_rstn  input  1: reset, synchronous, active-low.
REQ-007 Port i_fifo_empty  input  1: RX byte FIFO empty flag.
REQ-008 Port i_fifo_data  input  8: FIFO read data, valid the cycle after o_fifo_rden.
REQ-009 Port o_fifo_rden  output  1: single-cycle FIFO read strobe.
REQ-010 Port o_ddr_req  output  1: DDR write request, held until acknowledged.
REQ-011 Port i_ddr_ack  input  1: DDR controller accepts the request in the cycle it is sampled high with o_ddr_req.
REQ-012 Port o_ddr_addr  output  ADDR_W: write byte address.
REQ-013 Port o_ddr_wdata  output  128: packed write word; byte n in bits [8n+7:8n].
REQ-014 Port o_ddr_mask  output  16: byte-enable, 1 = byte valid.
REQ-015 Port o_busy  output  1: high whenever the FSM is not in IDLE or a partial word is held.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, LATCH, REQ.
REQ-017 IDLE -> FETCH when i_fifo_empty=0; IDLE otherwise holds.
REQ-018 FETCH SHALL assert o_fifo_rden for exactly one cycle, then go to LATCH.
REQ-019 LATCH SHALL write i_fifo_data into byte lane byte_cnt, set the corresponding mask bit and increment byte_cnt (4-bit).
REQ-020 LATCH with byte_cnt=15 before increment -> REQ; otherwise -> FETCH if i_fifo_empty=0, else IDLE.
REQ-021 Sustained throughput SHALL be one byte per 2 cycles while the FIFO is non-empty.
REQ-022 o_fifo_rden SHALL never assert in REQ or LATCH, nor when i_fifo_empty=1.
REQ-023 In REQ, o_ddr_req=1 and o_ddr_addr, o_ddr_wdata, o_ddr_mask SHALL stay stable until the ack cycle.
REQ-024 On the ack cycle: o_ddr_req deasserts next cycle, addr += ADDR_STEP modulo 2^ADDR_W (wraps to 0, not BASE_ADDR), byte_cnt, mask and wdata clear to 0, next state IDLE.
REQ-025 i_ddr_ack outside REQ SHALL be ignored.
REQ-026 The idle counter SHALL count cycles spent in IDLE with byte_cnt>0 and i_fifo_empty=1, clear on any other condition, and saturate at IDLE_TIMEOUT.

Reset
REQ-027 While i_rstn=0: state IDLE, o_fifo_rden=0, o_ddr_req=0, o_ddr_addr=BASE_ADDR, o_ddr_wdata=0, o_ddr_mask=0, byte_cnt=0, idle counter=0, o_busy=0.
REQ-028 Reset during REQ SHALL drop o_ddr_req the next cycle and discard the pending word; a byte read in FETCH and not yet latched is lost.

Configuration
REQ-029 Macro UART_DDR_FLUSH_EN defined: when the idle counter reaches IDLE_TIMEOUT, IDLE -> REQ with the partial word and its partial mask; address advances by ADDR_STEP on ack as in REQ-024.
REQ-030 Macro UART_DDR_FLUSH_EN undefined: no idle counter; a partial word is held indefinitely until 16 bytes arrive, and o_ddr_mask is 16'hFFFF in REQ.

Verification
REQ-031 Push 16 bytes 0x00..0x0F, ack 3 cycles after req -> one req, addr=0, wdata=128'h0F0E..0100, mask=16'hFFFF, next addr=16.
REQ-032 Push 32 bytes, hold ack low for 20 cycles on the first word -> no rden during REQ, outputs stable, second word at addr=16.
REQ-033 ADDR_W=8, BASE_ADDR=8'hF0, 32 bytes -> writes at 0xF0 then 0x00.
REQ-034 Flush enabled, IDLE_TIMEOUT=8, push 5 bytes then stop -> req after 8 idle cycles with mask=16'h001F; undefined -> no req.
REQ-035 Assert i_rstn=0 during REQ, push 16 new bytes -> req drops next cycle, new word at BASE_ADDR with only the new bytes.
REQ-036 FIFO toggles empty every cycle -> rden only when empty=0 in FETCH, no data loss, bytes in order.
